// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state, size and funct3 decode for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal_f3(input logic store, input logic [2:0] funct3);
    if (store)
      return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // The unsigned variants share the size encoding of their signed twins in funct3[1:0].
  function automatic lsu_size_t f3_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_word
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ins;

  always_comb begin
    shamt     = {addr, 3'b000};
    lane      = word >> shamt;
    ins       = wdata << shamt;
    load_data = word;
    mask      = '1;
    case (f3_size(funct3))
      SZ_B: begin
        load_data = funct3[2] ? {{(XLEN-8){1'b0}}, lane[7:0]}
                              : {{(XLEN-8){lane[7]}}, lane[7:0]};
        mask      = {{(XLEN-8){1'b0}}, 8'hFF} << shamt;
      end
      SZ_H: begin
        load_data = funct3[2] ? {{(XLEN-16){1'b0}}, lane[15:0]}
                              : {{(XLEN-16){lane[15]}}, lane[15:0]};
        mask      = {{(XLEN-16){1'b0}}, 16'hFFFF} << shamt;
      end
      default: begin
        load_data = word;
        mask      = '1;
      end
    endcase
    merged_word = (word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store initiator driving a word-organised data memory
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 64,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state, state_next;
  lsu_size_t       req_size;
  logic            req_err;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  always_comb begin
    req_size = f3_size(req_funct3);
    req_err  = !is_legal_f3(req_store, req_funct3)
             || (req_size == SZ_H && req_addr[0])
             || (req_size == SZ_W && req_addr[1:0] != 2'b00)
             || ((req_addr >> 2) >= XLEN'(MEM_DEPTH));
  end

  lsu_byte_lane #(.XLEN(XLEN)) u_lane (
    .word        (mem_rdata),
    .addr        (addr_q[1:0]),
    .funct3      (funct3_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // resp_rdata only changes on the edge that enters RESP, so it holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            if (req_err)
              rdata_q <= '0;
          end
        end
        RD: begin
          if (store_q)
            wdata_q <= merged_word;
          else
            rdata_q <= load_data;
        end
        WR:      rdata_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)
            state_next = RESP;
          else if (!req_store || req_size != SZ_W)
            state_next = RD;
          else
            state_next = WR;
        end
      end
      RD: begin
        mem_read   = 1'b1;
        mem_addr   = addr_q >> 2;
        state_next = store_q ? WR : RESP;
      end
      WR: begin
        mem_write  = 1'b1;
        mem_addr   = addr_q >> 2;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_wdata  = (state == WR) ? wdata_q : '0;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - randomized scoreboard bench for lsu_mem_ctrl against a byte-level memory model
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd_ph;
    int          wr_ph;
    logic [31:0] word;
    logic [31:0] wword;
    int          acc;
  } exp_t;

  logic [31:0] seed_mem [64];
  logic [31:0] mem      [64];
  logic [31:0] ref_mem  [64];
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  logic        load_mem;
  logic        do_final;
  logic        final_done = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_DEPTH(64), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (load_mem)
      mem <= seed_mem;
    else if (mem_write)
      mem[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, want, $time);
    end
  endtask

  // Expected outcome from the ISA rules: size in bytes, byte-wise store, shift-and-extend load.
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          nb;
    int          off;
    logic        legal;
    logic [31:0] v;
    nb      = 1 << f3[1:0];
    off     = int'(a[1:0]);
    legal   = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e.word  = a >> 2;
    e.rdata = 32'h0;
    e.wword = 32'h0;
    e.rd_ph = 0;
    e.wr_ph = 0;
    e.acc   = 0;
    e.err   = !legal || (off % nb) != 0 || e.word >= 64;
    if (e.err) begin
      e.lat = 1;
    end else if (!st) begin
      v = ref_mem[e.word[5:0]] >> (8 * off);
      if (nb == 1)
        v = f3[2] ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
      else if (nb == 2)
        v = f3[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
      e.rdata = v;
      e.rd_ph = 1;
      e.lat   = 2;
    end else begin
      v = ref_mem[e.word[5:0]];
      for (int i = 0; i < nb; i++)
        v[8*(off+i) +: 8] = wd[8*i +: 8];
      e.wword = v;
      e.rd_ph = (nb < 4) ? 1 : 0;
      e.wr_ph = (nb < 4) ? 2 : 1;
      e.lat   = e.wr_ph + 1;
    end
    return e;
  endfunction

  // Scoreboard: accepts push at the rising edge, everything is checked on the falling edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset && !load_mem && req_valid && req_ready) begin
      exp_t e;
      e     = model(req_store, req_funct3, req_addr, req_wdata);
      e.acc = cyc;
      q.push_back(e);
      acc_cnt++;
    end
    @(negedge clk);
    if (load_mem)
      ref_mem = seed_mem;
    if (reset) begin
      q.delete();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_resp_valid", resp_valid, 0);
    end else if (q.size() != 0) begin
      int ph;
      ph = cyc - q[0].acc + 1;
      chk("busy_req_ready", req_ready, 0);
      if (ph == q[0].rd_ph) begin
        chk("rd_mem_read", mem_read, 1);
        chk("rd_mem_write", mem_write, 0);
        chk("rd_mem_addr", mem_addr, q[0].word);
      end else if (ph == q[0].wr_ph) begin
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_read", mem_read, 0);
        chk("wr_mem_addr", mem_addr, q[0].word);
        chk("wr_mem_wdata", mem_wdata, q[0].wword);
      end else begin
        chk("quiet_mem_read", mem_read, 0);
        chk("quiet_mem_write", mem_write, 0);
      end
      if (ph == q[0].lat) begin
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, q[0].err);
        chk("resp_rdata", resp_rdata, q[0].rdata);
        if (q[0].wr_ph != 0)
          ref_mem[q[0].word[5:0]] = q[0].wword;
        void'(q.pop_front());
      end else begin
        chk("early_resp_valid", resp_valid, 0);
      end
    end else begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_resp_valid", resp_valid, 0);
    end
    if (do_final && !final_done) begin
      for (int i = 0; i < 64; i++)
        chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
      final_done = 1'b1;
    end
  end

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit hold);
    int n0;
    int t;
    n0         = acc_cnt;
    t          = 0;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    while (acc_cnt == n0) begin
      @(negedge clk);
      t++;
      if (t > 20) begin
        $display("FAIL accept_timeout: got no accept want accept within 20 cycles");
        $fatal(1, "request never accepted");
      end
    end
    if (!hold)
      req_valid = 1'b0;
  endtask

  initial begin
    int          t;
    int          nb;
    int          k;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    reset      = 1'b1;
    load_mem   = 1'b1;
    do_final   = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 64; i++)
      seed_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    reset    = 1'b0;
    @(negedge clk);

    send(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 1'b0);
    send(1'b0, 3'b000, 32'h17, 32'h0, 1'b0);
    send(1'b0, 3'b100, 32'h17, 32'h0, 1'b0);
    send(1'b0, 3'b101, 32'h14, 32'h0, 1'b0);
    send(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
    send(1'b1, 3'b001, 32'h16, 32'hAAAA1234, 1'b0);
    send(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
    send(1'b0, 3'b001, 32'h15, 32'h0, 1'b0);
    send(1'b1, 3'b010, 32'h102, 32'h12345678, 1'b0);
    send(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
    send(1'b0, 3'b011, 32'h14, 32'h0, 1'b0);
    send(1'b1, 3'b100, 32'h14, 32'h0, 1'b0);
    send(1'b0, 3'b000, 32'hFC, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    // SB to 0x10 interrupted by reset while the read phase is on the bus.
    send(1'b1, 3'b000, 32'h10, 32'h0000005A, 1'b0);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    send(1'b1, 3'b000, 32'h21, 32'h000000C3, 1'b1);
    send(1'b0, 3'b000, 32'h21, 32'h0, 1'b1);
    send(1'b1, 3'b001, 32'h27, 32'h0000BEEF, 1'b1);
    send(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b1);
    send(1'b0, 3'b101, 32'h42, 32'h0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      st = 1'(($urandom % 2));
      if ($urandom % 8 < 6) begin
        k  = int'($urandom % (st ? 3 : 5));
        f3 = 3'(k < 3 ? k : k + 1);
      end else begin
        f3 = 3'($urandom % 8);
      end
      nb = 1 << f3[1:0];
      if (nb > 4)
        nb = 4;
      a = (32'($urandom % 72) << 2);
      if ($urandom % 5 == 0)
        a = a | 32'($urandom % 4);
      else
        a = a | 32'((($urandom % 4) / nb) * nb);
      if ($urandom % 25 == 0)
        a[31] = 1'b1;
      send(st, f3, a, $urandom, 1'($urandom % 2));
      if ($urandom % 4 == 0) begin
        req_valid = 1'b0;
        repeat ($urandom % 3) @(negedge clk);
      end
    end

    req_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    do_final = 1'b1;
    t = 0;
    while (!final_done && t < 5) begin
      @(negedge clk);
      t++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
